// File: rtl/id_stage_pkg.sv
// Opcode/funct encodings, ALU op codes and the instruction decoder shared by the ID stage.
package id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FUNC_SLL = 6'h00;
    localparam logic [5:0] FUNC_SRL = 6'h02;
    localparam logic [5:0] FUNC_SRA = 6'h03;
    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;
    localparam logic [5:0] FUNC_NOR = 6'h27;
    localparam logic [5:0] FUNC_SLT = 6'h2a;

    localparam logic [3:0] ALUC_ADD = 4'd0;
    localparam logic [3:0] ALUC_SUB = 4'd1;
    localparam logic [3:0] ALUC_AND = 4'd2;
    localparam logic [3:0] ALUC_OR  = 4'd3;
    localparam logic [3:0] ALUC_NOR = 4'd4;
    localparam logic [3:0] ALUC_SLT = 4'd5;
    localparam logic [3:0] ALUC_SLL = 4'd6;
    localparam logic [3:0] ALUC_SRL = 4'd7;
    localparam logic [3:0] ALUC_SRA = 4'd8;

    typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT, IMM_SHAMT} imm_sel_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       aluimm;
        logic       shift;
        logic [3:0] aluc;
        logic       rd_is_rd;
        logic       use_rs;
        logic       use_rt;
        logic       is_beq;
        logic       is_bne;
        logic       is_j;
        imm_sel_t   imm_sel;
    } ctrl_t;

    // Unknown opcodes and functs fall through to an all-zero (NOP) control word.
    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t c;
        c = '0;
        case (inst[31:26])
            OP_RTYPE: begin
                c.wreg     = 1'b1;
                c.rd_is_rd = 1'b1;
                c.use_rs   = 1'b1;
                c.use_rt   = 1'b1;
                case (inst[5:0])
                    FUNC_ADD: c.aluc = ALUC_ADD;
                    FUNC_SUB: c.aluc = ALUC_SUB;
                    FUNC_AND: c.aluc = ALUC_AND;
                    FUNC_OR:  c.aluc = ALUC_OR;
                    FUNC_NOR: c.aluc = ALUC_NOR;
                    FUNC_SLT: c.aluc = ALUC_SLT;
                    FUNC_SLL, FUNC_SRL, FUNC_SRA: begin
                        c.aluc    = (inst[5:0] == FUNC_SLL) ? ALUC_SLL :
                                    (inst[5:0] == FUNC_SRL) ? ALUC_SRL : ALUC_SRA;
                        c.shift   = 1'b1;
                        c.use_rs  = 1'b0;
                        c.imm_sel = IMM_SHAMT;
                    end
                    default: c = '0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
                c.wreg    = 1'b1;
                c.aluimm  = 1'b1;
                c.use_rs  = 1'b1;
                c.m2reg   = (inst[31:26] == OP_LW);
                c.aluc    = (inst[31:26] == OP_ANDI) ? ALUC_AND :
                            (inst[31:26] == OP_ORI)  ? ALUC_OR  : ALUC_ADD;
                c.imm_sel = (inst[31:26] == OP_ANDI || inst[31:26] == OP_ORI) ? IMM_ZEXT : IMM_SEXT;
            end
            OP_SW: begin
                c.wmem    = 1'b1;
                c.aluimm  = 1'b1;
                c.use_rs  = 1'b1;
                c.use_rt  = 1'b1;
                c.aluc    = ALUC_ADD;
                c.imm_sel = IMM_SEXT;
            end
            OP_BEQ, OP_BNE: begin
                c.use_rs  = 1'b1;
                c.use_rt  = 1'b1;
                c.is_beq  = (inst[31:26] == OP_BEQ);
                c.is_bne  = (inst[31:26] == OP_BNE);
                c.imm_sel = IMM_SEXT;
            end
            OP_J:    c.is_j = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Register file: write on falling clk edge so the same-cycle decode sees WB data; two async reads, r0 reads zero.
module reg_file #(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int AW      = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [REG_NUM];

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/id_stage.sv
// Decode stage: decode, register read, RAW stall, beq/bne/j resolve, ID/EX register (bubble on stall).
// Optional FORWARD_EN: EX > MEM > register-file operand forwarding, stalling only on load-use.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_inst,
    input  logic [31:0]       if_pc4,
    input  logic              wb_wreg,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_wreg,
    input  logic              ex_m2reg,
    input  logic [4:0]        ex_rd,
    input  logic              mem_wreg,
    input  logic              mem_m2reg,
    input  logic [4:0]        mem_rd,
    input  logic [DATA_W-1:0] ex_res,
    input  logic [DATA_W-1:0] mem_res,
    output logic              stall,
    output logic              ctrl_branch,
    output logic [31:0]       nid_pc,
    output logic              id_wreg,
    output logic              id_m2reg,
    output logic              id_wmem,
    output logic              id_aluimm,
    output logic              id_shift,
    output logic [3:0]        id_aluc,
    output logic [DATA_W-1:0] id_a,
    output logic [DATA_W-1:0] id_b,
    output logic [DATA_W-1:0] id_imm,
    output logic [4:0]        id_rd,
    output logic              id_valid
);

    ctrl_t             c;
    logic [4:0]        rs, rt, rd_dec;
    logic [DATA_W-1:0] rf_a, rf_b, opa, opb, imm_val;
    logic [31:0]       br_off;

    assign rs = if_inst[25:21];
    assign rt = if_inst[20:16];
    assign c  = decode(if_inst);

    reg_file #(.REG_NUM(REG_NUM), .DATA_W(DATA_W)) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_wreg),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs),
        .rdata_a (rf_a),
        .raddr_b (rt),
        .rdata_b (rf_b)
    );

    function automatic logic hit(input logic [4:0] src, input logic wr, input logic [4:0] dst);
        return wr && (src != 5'd0) && (dst == src);
    endfunction

`ifdef FORWARD_EN
    always_comb begin
        opa = hit(rs, ex_wreg, ex_rd) ? ex_res : hit(rs, mem_wreg, mem_rd) ? mem_res : rf_a;
        opb = hit(rt, ex_wreg, ex_rd) ? ex_res : hit(rt, mem_wreg, mem_rd) ? mem_res : rf_b;
        stall = (c.use_rs && hit(rs, ex_wreg && ex_m2reg, ex_rd)) ||
                (c.use_rt && hit(rt, ex_wreg && ex_m2reg, ex_rd));
    end

    logic unused_fwd;
    assign unused_fwd = mem_m2reg;
`else
    always_comb begin
        opa = rf_a;
        opb = rf_b;
        stall = (c.use_rs && (hit(rs, ex_wreg, ex_rd) || hit(rs, mem_wreg, mem_rd))) ||
                (c.use_rt && (hit(rt, ex_wreg, ex_rd) || hit(rt, mem_wreg, mem_rd)));
    end

    logic unused_fwd;
    assign unused_fwd = ^{ex_res, mem_res, ex_m2reg, mem_m2reg};
`endif

    always_comb begin
        case (c.imm_sel)
            IMM_SEXT:  imm_val = {{(DATA_W-16){if_inst[15]}}, if_inst[15:0]};
            IMM_ZEXT:  imm_val = {{(DATA_W-16){1'b0}}, if_inst[15:0]};
            IMM_SHAMT: imm_val = {{(DATA_W-5){1'b0}}, if_inst[10:6]};
            default:   imm_val = '0;
        endcase
    end

    assign rd_dec = !c.wreg ? 5'd0 : (c.rd_is_rd ? if_inst[15:11] : rt);

    // Target is word-addressed: PC+1 plus the signed offset, no shift.
    assign br_off      = {{16{if_inst[15]}}, if_inst[15:0]};
    assign nid_pc      = c.is_j ? {if_pc4[31:26], if_inst[25:0]} : (if_pc4 + br_off);
    assign ctrl_branch = !stall && (c.is_j || (c.is_beq && opa == opb) || (c.is_bne && opa != opb));

    always_ff @(posedge clk or posedge rst) begin
        if (rst || stall) begin
            id_wreg   <= 1'b0;
            id_m2reg  <= 1'b0;
            id_wmem   <= 1'b0;
            id_aluimm <= 1'b0;
            id_shift  <= 1'b0;
            id_aluc   <= 4'd0;
            id_a      <= '0;
            id_b      <= '0;
            id_imm    <= '0;
            id_rd     <= 5'd0;
            id_valid  <= 1'b0;
        end else begin
            id_wreg   <= c.wreg;
            id_m2reg  <= c.m2reg;
            id_wmem   <= c.wmem;
            id_aluimm <= c.aluimm;
            id_shift  <= c.shift;
            id_aluc   <= c.aluc;
            id_a      <= opa;
            id_b      <= opb;
            id_imm    <= imm_val;
            id_rd     <= rd_dec;
            id_valid  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized decode against a behavioural model.
module tb_id_stage;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_inst, if_pc4, wb_data, ex_res, mem_res;
    logic        wb_wreg, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
    logic [4:0]  wb_rd, ex_rd, mem_rd;
    logic        stall, ctrl_branch;
    logic [31:0] nid_pc;
    logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_valid;
    logic [3:0]  id_aluc;
    logic [31:0] id_a, id_b, id_imm;
    logic [4:0]  id_rd;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] srf [32];

    id_stage dut (
        .clk(clk), .rst(rst), .if_inst(if_inst), .if_pc4(if_pc4),
        .wb_wreg(wb_wreg), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd(mem_rd),
        .ex_res(ex_res), .mem_res(mem_res),
        .stall(stall), .ctrl_branch(ctrl_branch), .nid_pc(nid_pc),
        .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
        .id_aluimm(id_aluimm), .id_shift(id_shift), .id_aluc(id_aluc),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_rd(id_rd), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    // MIPS encodings and ALU codes as listed in the design description.
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25,
                           F_NOR = 6'h27, F_SLT = 6'h2a, F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
    localparam logic [5:0] O_J = 6'h02, O_BEQ = 6'h04, O_BNE = 6'h05, O_ADDI = 6'h08,
                           O_ANDI = 6'h0c, O_ORI = 6'h0d, O_LW = 6'h23, O_SW = 6'h2b;

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd, sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    typedef struct {
        bit          stall, br, wreg, m2reg, wmem, aluimm, shift, use_a, use_b, chk_imm;
        logic [3:0]  aluc;
        logic [31:0] npc, a, b, imm;
        logic [4:0]  rd;
    } exp_t;

    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (FWD && ex_wreg && ex_rd == r) return ex_res;
        if (FWD && mem_wreg && mem_rd == r) return mem_res;
        return srf[r];
    endfunction

    function automatic bit hazard(input logic [4:0] r);
        if (r == 0) return 1'b0;
        if (FWD) return ex_wreg && ex_m2reg && ex_rd == r;
        return (ex_wreg && ex_rd == r) || (mem_wreg && mem_rd == r);
    endfunction

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc4);
        exp_t e;
        logic [31:0] sx, zx;
        bit is_j, is_beq, is_bne;
        e = '{default: 0};
        sx = {{16{inst[15]}}, inst[15:0]};
        zx = {16'd0, inst[15:0]};
        is_j = 0; is_beq = 0; is_bne = 0;
        case (inst[31:26])
            6'h00: begin
                e.wreg = 1; e.rd = inst[15:11]; e.use_a = 1; e.use_b = 1;
                case (inst[5:0])
                    F_ADD: e.aluc = 0;  F_SUB: e.aluc = 1;  F_AND: e.aluc = 2;
                    F_OR:  e.aluc = 3;  F_NOR: e.aluc = 4;  F_SLT: e.aluc = 5;
                    F_SLL, F_SRL, F_SRA: begin
                        e.aluc = (inst[5:0] == F_SLL) ? 4'd6 : (inst[5:0] == F_SRL) ? 4'd7 : 4'd8;
                        e.shift = 1; e.use_a = 0; e.imm = {27'd0, inst[10:6]}; e.chk_imm = 1;
                    end
                    default: e = '{default: 0};
                endcase
            end
            O_ADDI: begin e.wreg = 1; e.aluimm = 1; e.rd = inst[20:16]; e.imm = sx; e.aluc = 0; end
            O_ANDI: begin e.wreg = 1; e.aluimm = 1; e.rd = inst[20:16]; e.imm = zx; e.aluc = 2; end
            O_ORI:  begin e.wreg = 1; e.aluimm = 1; e.rd = inst[20:16]; e.imm = zx; e.aluc = 3; end
            O_LW:   begin e.wreg = 1; e.m2reg = 1; e.aluimm = 1; e.rd = inst[20:16]; e.imm = sx; end
            O_SW:   begin e.wmem = 1; e.aluimm = 1; e.imm = sx; e.use_b = 1; end
            O_BEQ:  begin is_beq = 1; e.use_b = 1; end
            O_BNE:  begin is_bne = 1; e.use_b = 1; end
            O_J:    is_j = 1;
            default: ;
        endcase
        if (inst[31:26] inside {O_ADDI, O_ANDI, O_ORI, O_LW, O_SW, O_BEQ, O_BNE}) e.use_a = 1;
        if (inst[31:26] inside {O_ADDI, O_ANDI, O_ORI, O_LW, O_SW}) e.chk_imm = 1;
        e.a = operand(inst[25:21]);
        e.b = operand(inst[20:16]);
        e.stall = (e.use_a && hazard(inst[25:21])) || (e.use_b && hazard(inst[20:16]));
        e.br = !e.stall && (is_j || (is_beq && e.a == e.b) || (is_bne && e.a != e.b));
        e.npc = is_j ? {pc4[31:26], inst[25:0]} : pc4 + sx;
        return e;
    endfunction

    task automatic drive(input logic [31:0] inst, pc4, input bit wv, input logic [4:0] wr,
                         input logic [31:0] wd, input bit exw, exm, input logic [4:0] exd,
                         input bit mw, input logic [4:0] md);
        if_inst = inst; if_pc4 = pc4;
        wb_wreg = wv; wb_rd = wr; wb_data = wd;
        ex_wreg = exw; ex_m2reg = exm; ex_rd = exd;
        mem_wreg = mw; mem_m2reg = 1'b0; mem_rd = md;
    endtask

    // Wait for the register-file write edge and mirror the WB write in the shadow copy.
    task automatic to_negedge();
        @(negedge clk); #1;
        if (wb_wreg && wb_rd != 0) srf[wb_rd] = wb_data;
    endtask

    task automatic to_posedge();
        @(posedge clk); #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        drive(32'd0, 32'd0, 1, r, d, 0, 0, 0, 0, 0);
        to_negedge();
        to_posedge();
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_res = 0; mem_res = 0;
        drive(32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        foreach (srf[i]) srf[i] = 32'd0;
        #2;
        n_cmp++;
        if ({id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_aluc, id_a, id_b, id_imm, id_rd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b a=%h b=%h imm=%h rd=%0d, required all zero", id_valid, id_a, id_b, id_imm, id_rd);
        end
        to_posedge(); to_posedge();
        rst = 1'b0;
    endtask

    task automatic test_independent();
        wb_write(1, 5);
        wb_write(2, 7);
        drive(rtype(F_ADD, 1, 2, 3, 0), 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
        to_negedge();
        n_cmp++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL indep_stall: got %b want 0", stall); end
        to_posedge();
        n_cmp++;
        if ({id_a, id_b, id_aluc, id_rd, id_valid, id_wreg} !== {32'd5, 32'd7, 4'd0, 5'd3, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL indep_add: a=%0d b=%0d aluc=%0d rd=%0d valid=%b wreg=%b want 5 7 0 3 1 1",
                     id_a, id_b, id_aluc, id_rd, id_valid, id_wreg);
        end
    endtask

    task automatic test_raw_and_load_use();
        ex_res = 32'd9;
        drive(rtype(F_SUB, 1, 2, 4, 0), 32'h8, 0, 0, 0, 1, 0, 1, 0, 0);
        to_negedge();
        n_cmp++;
        if (stall !== !FWD) begin n_fail++; $display("FAIL raw_ex_stall: got %b want %b", stall, !FWD); end
        to_posedge();
        n_cmp++;
        if (FWD ? (id_valid !== 1'b1 || id_a !== 32'd9 || id_aluc !== 4'd1) : (id_valid !== 1'b0 || id_aluc !== 4'd0)) begin
            n_fail++;
            $display("FAIL raw_ex_idex: valid=%b a=%0d aluc=%0d (forward build=%b)", id_valid, id_a, id_aluc, FWD);
        end
        drive(rtype(F_OR, 2, 0, 5, 0), 32'hc, 0, 0, 0, 1, 1, 2, 0, 0);
        to_negedge();
        n_cmp++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
        to_posedge();
        n_cmp++;
        if (id_valid !== 1'b0 || id_wreg !== 1'b0) begin
            n_fail++; $display("FAIL load_use_bubble: valid=%b wreg=%b want 0 0", id_valid, id_wreg);
        end
        drive(rtype(F_OR, 2, 0, 5, 0), 32'hc, 0, 0, 0, 0, 0, 0, 0, 0);
        to_negedge();
        n_cmp++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: stall=%b want 0", stall); end
        to_posedge();
        n_cmp++;
        if ({id_valid, id_a, id_aluc, id_rd} !== {1'b1, 32'd7, 4'd3, 5'd5}) begin
            n_fail++; $display("FAIL load_use_decode: valid=%b a=%0d aluc=%0d rd=%0d want 1 7 3 5", id_valid, id_a, id_aluc, id_rd);
        end
        // Pending writes to r0 in EX and MEM must not stall a reader of r0.
        drive(rtype(F_ADD, 0, 0, 6, 0), 32'h10, 0, 0, 0, 1, 1, 0, 1, 0);
        to_negedge();
        n_cmp++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_no_stall: stall=%b want 0", stall); end
        // WB write in the same cycle as the read returns the new value.
        drive(rtype(F_ADD, 1, 2, 7, 0), 32'h14, 1, 1, 32'h55, 0, 0, 0, 0, 0);
        to_negedge();
        to_posedge();
        n_cmp++;
        if (id_a !== 32'h55) begin n_fail++; $display("FAIL wb_bypass: a=%h want 55", id_a); end
    endtask

    task automatic test_branch();
        logic [31:0] beq_i, bne_i;
        beq_i = itype(O_BEQ, 1, 2, 16'hfffc);
        bne_i = itype(O_BNE, 1, 2, 16'hfffc);
        wb_write(1, 3);
        wb_write(2, 3);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) wb_write(2, 4);
            drive((k % 2 == 0) ? beq_i : bne_i, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0);
            to_negedge();
            n_cmp++;
            if (ctrl_branch !== (k == 0 || k == 3) || nid_pc !== 32'h0c) begin
                n_fail++;
                $display("FAIL branch_case%0d: ctrl_branch=%b nid_pc=%h want %b 0000000c", k, ctrl_branch, nid_pc, (k == 0 || k == 3));
            end
            to_posedge();
        end
        // Branch on a not-yet-written operand: stalls (no redirect) unless EX can forward equal data.
        ex_res = 32'd3;
        drive(beq_i, 32'h10, 0, 0, 0, 1, 0, 2, 0, 0);
        to_negedge();
        n_cmp++;
        if (ctrl_branch !== FWD || stall !== !FWD) begin
            n_fail++; $display("FAIL branch_hazard: ctrl_branch=%b stall=%b want %b %b", ctrl_branch, stall, FWD, !FWD);
        end
        to_posedge();
    endtask

    task automatic test_jump_and_unknown();
        drive({O_J, 26'h0000020}, 32'h84000010, 0, 0, 0, 0, 0, 0, 0, 0);
        to_negedge();
        n_cmp++;
        if (ctrl_branch !== 1'b1 || nid_pc !== 32'h84000020) begin
            n_fail++; $display("FAIL jump: ctrl_branch=%b nid_pc=%h want 1 84000020", ctrl_branch, nid_pc);
        end
        to_posedge();
        drive({6'h3f, 26'h3ffffff}, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
        to_negedge();
        to_posedge();
        n_cmp++;
        if ({id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_aluc, id_valid} !== {9'd0, 1'b1}) begin
            n_fail++; $display("FAIL unknown_nop: wreg=%b m2reg=%b wmem=%b aluimm=%b shift=%b aluc=%0d valid=%b",
                               id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_aluc, id_valid);
        end
    endtask

    task automatic test_random();
        logic [5:0] rfn [9] = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLL, F_SRL, F_SRA};
        logic [5:0] iop [8] = '{O_ADDI, O_ANDI, O_ORI, O_LW, O_SW, O_BEQ, O_BNE, O_J};
        logic [31:0] inst, pc4;
        exp_t e;
        int sel;
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 16);
            inst = $urandom;
            if (sel < 9) inst = rtype(rfn[sel], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), inst[15:11], inst[10:6]);
            else if (iop[sel-9] != O_J) inst = itype(iop[sel-9], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), inst[15:0]);
            else inst = {O_J, inst[25:0]};
            pc4 = $urandom;
            ex_res = $urandom; mem_res = $urandom;
            drive(inst, pc4, bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  bit'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
            to_negedge();
            e = model(inst, pc4);
            n_cmp++;
            if (stall !== e.stall || ctrl_branch !== e.br || (e.br && nid_pc !== e.npc)) begin
                n_fail++;
                $display("FAIL rand_comb inst=%h: stall=%b br=%b npc=%h want %b %b %h", inst, stall, ctrl_branch, nid_pc, e.stall, e.br, e.npc);
            end
            to_posedge();
            n_cmp++;
            if (e.stall) begin
                if ({id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_aluc, id_a, id_b, id_imm, id_rd} !== '0) begin
                    n_fail++; $display("FAIL rand_bubble inst=%h: valid=%b a=%h b=%h imm=%h rd=%0d want all zero", inst, id_valid, id_a, id_b, id_imm, id_rd);
                end
            end else if ({id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_aluc} !==
                          {1'b1, e.wreg, e.m2reg, e.wmem, e.aluimm, e.shift, e.aluc} ||
                         (e.use_a && id_a !== e.a) || (e.use_b && id_b !== e.b) ||
                         (e.chk_imm && id_imm !== e.imm) || (e.wreg && id_rd !== e.rd)) begin
                n_fail++;
                $display("FAIL rand_decode inst=%h: ctl=%b%b%b%b%b aluc=%0d a=%h b=%h imm=%h rd=%0d want ctl=%b%b%b%b%b aluc=%0d a=%h b=%h imm=%h rd=%0d",
                         inst, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_aluc, id_a, id_b, id_imm, id_rd,
                         e.wreg, e.m2reg, e.wmem, e.aluimm, e.shift, e.aluc, e.a, e.b, e.imm, e.rd);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        wb_write(1, 32'h1234);
        drive(rtype(F_ADD, 1, 2, 3, 0), 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
        to_negedge();
        to_posedge();
        n_cmp++;
        if (id_valid !== 1'b1 || id_a !== 32'h1234) begin
            n_fail++; $display("FAIL pre_reset_load: valid=%b a=%h want 1 1234", id_valid, id_a);
        end
        drive(rtype(F_OR, 2, 0, 5, 0), 32'h8, 0, 0, 0, 1, 1, 2, 0, 0);
        to_negedge();
        rst = 1'b1;
        foreach (srf[i]) srf[i] = 32'd0;
        #1;
        n_cmp++;
        if ({id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_aluc, id_a, id_b, id_imm, id_rd} !== '0) begin
            n_fail++; $display("FAIL async_reset: valid=%b wreg=%b a=%h rd=%0d want all zero", id_valid, id_wreg, id_a, id_rd);
        end
        to_posedge();
        rst = 1'b0;
        drive(rtype(F_ADD, 0, 1, 3, 0), 32'hc, 1, 0, 32'hdead, 0, 0, 0, 0, 0);
        to_negedge();
        to_posedge();
        n_cmp++;
        if ({id_valid, id_a, id_b} !== {1'b1, 32'd0, 32'd0}) begin
            n_fail++; $display("FAIL post_reset_read: valid=%b a=%h b=%h want 1 0 0", id_valid, id_a, id_b);
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_and_load_use();
        test_branch();
        test_jump_and_unknown();
        test_random();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS-subset pipeline; consumes the registered instruction and PC+1 from the fetch stage.
- Functions: decodes the instruction, reads the register file, detects RAW hazards, resolves beq/bne/j, and loads the ID/EX pipeline register.
- Returns ctrl_branch/nid_pc to the fetch stage; stall holds the PC and IF/ID register.

Parameters:
- REG_NUM, 32, register-file depth; r0 hard-wired to zero.
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset
- if_inst  in  32  instruction held in IF/ID
- if_pc4  in  32  PC+1 of that instruction (word-addressed PC)
- wb_wreg  in  1  WB register-write enable
- wb_rd  in  5  WB destination
- wb_data  in  32  WB write data
- ex_wreg, ex_m2reg  in  1,1  EX-stage write enable / is-load
- ex_rd  in  5  EX destination
- mem_wreg, mem_m2reg  in  1,1  MEM-stage write enable / is-load
- mem_rd  in  5  MEM destination
- ex_res, mem_res  in  32,32  forwarding data (used only with FORWARD_EN)
- stall  out  1  hold PC and IF/ID this cycle
- ctrl_branch  out  1  redirect fetch to nid_pc
- nid_pc  out  32  branch/jump target
- id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift  out  1 each  ID/EX control
- id_aluc  out  4  ALU op code
- id_a, id_b, id_imm  out  32 each  operand A, operand B, extended immediate
- id_rd  out  5  destination register
- id_valid  out  1  ID/EX holds a real instruction (0 = bubble)

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk. On reset, all id_* outputs are 0 and every register-file entry is 0.
- Decode is combinational from if_inst.
  - R-type add/sub/and/or/nor/slt/sll/srl/sra: rd = inst[15:11]; sll/srl/sra set id_shift, with shamt = inst[10:6] placed in id_imm.
  - addi: sign-extends the immediate.
  - andi/ori: zero-extend the immediate.
  - lw/sw: sign-extend the immediate. lw sets id_m2reg and id_wreg with rd = rt; sw sets id_wmem.
  - Unknown opcode/funct: decodes as NOP (all control 0).
- Register file:
  - Written on the falling edge of clk when wb_wreg=1 and wb_rd!=0, so a WB write is visible to the same-cycle ID read.
  - Reads are asynchronous; reading r0 returns 0.
- Source use: rs is used by every instruction except j and shifts. rt is used by R-type, sw, beq and bne.
- Hazard (default build): stall=1 if a used source register s!=0 and either (ex_wreg and ex_rd==s) or (mem_wreg and mem_rd==s).
- Branch and jump targets:
  - beq/bne: target = if_pc4 + sext(imm16), modulo 2^32.
  - j: target = {if_pc4[31:26], inst[25:0]}.
- ctrl_branch = !stall and (j, or beq with a==b, or bne with a!=b). Compare uses the post-forward operand values.
- There is one branch delay slot: the instruction fetched during resolution is not flushed.
- ID/EX register on posedge clk:
  - stall=1: loads a bubble (all control 0, id_valid=0, data 0).
  - Otherwise: loads the decoded instruction with id_valid=1.
- Simultaneous WB write and ID read of the same register returns the new data.
- Hazard on r0 never stalls.
- Reset asserted mid-stall clears the bubble and register file immediately; after rst falls, the first posedge loads a normal decode.

Optional Feature:
- Macro FORWARD_EN.
- Defined:
  - Operand mux priority is EX (ex_res) > MEM (mem_res) > register file.
  - stall=1 only when a used source matches ex_rd with ex_wreg and ex_m2reg (load-use).
  - Branch compare uses the forwarded values.
- Undefined: ex_res and mem_res are ignored; the full stall rule above applies.

Decomposition:
- Shared header macro.vh holds the OP_* and FUNC_* opcodes plus new ALUC_* codes:
  - ALUC_ADD=0, SUB=1, AND=2, OR=3, NOR=4, SLT=5, SLL=6, SRL=7, SRA=8.
- One sub-module: reg_file, holding the 32x32 array with the negedge write port and two async read ports.

Test Plan:
- Independent ops: wb writes r1=5, r2=7; issue add r3,r1,r2 → next posedge id_a=5, id_b=7, id_aluc=ALUC_ADD, id_rd=3, id_valid=1, stall=0.
- RAW in EX: ex_wreg=1, ex_rd=1; issue sub r4,r1,r2.
  - Default build: stall=1 and a bubble is loaded (id_valid=0).
  - FORWARD_EN with ex_res=9: no stall, id_a=9.
- Load-use: ex_m2reg=1, ex_wreg=1, ex_rd=2; issue or r5,r2,r0 → stall=1 in both builds; once EX clears, stall=0 and normal decode.
- Branch taken: r1=r2=3, if_pc4=0x10, beq r1,r2,-4 → ctrl_branch=1, nid_pc=0x0C. With r2=4 → ctrl_branch=0. Same operands with bne → the inverse result.
- Jump: if_pc4=0x84000010, j 0x0000020 → nid_pc=0x84000020, ctrl_branch=1.
- Async reset during stall → all outputs 0 immediately; a subsequent read of r1 returns 0; writes to r0 are ignored.
